ph_readout_ctrl: RTL

Sequences readout of the baseline-subtracted pulse-height FIFO into the HS-PH user stream. It waits for a complete frame (FIFO full), drains it with a latency-matched read pipeline, and emits a header-tagged packet over a valid/ready stream. It also recovers from stale or overrun frames by pulsing the FIFO flush, and keeps frame, drop and error counters for AXI status readback.

---
 rtl/ph_readout_if.sv | 23 ++
 rtl/ph_readout_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ph_readout_if.sv
// Pulse-height FIFO read port and HS-PH output stream bundled for ph_readout_ctrl.
// master is the controller's view; slave is the FIFO/stream environment's view.
interface ph_readout_if;
    logic        ph_cache_valid;
    logic        ph_ready;
    logic [31:0] ph_rdata;
    logic        ph_rd_en;
    logic        ph_fifo_flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        input  ph_cache_valid, ph_ready, ph_rdata, out_ready,
        output ph_rd_en, ph_fifo_flush, out_valid, out_data, out_last
    );

    modport slave (
        output ph_cache_valid, ph_ready, ph_rdata, out_ready,
        input  ph_rd_en, ph_fifo_flush, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ph_readout_ctrl.sv
// Drains one complete pulse-height frame from the FIFO into a header-tagged stream packet,
// flushing stale, dropped or overrun frames and keeping frame/drop/error counters.
module ph_readout_ctrl #(
    parameter int unsigned NPIX        = 256,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned FLUSH_CYC   = 4,
    parameter logic [15:0] HDR_TAG     = 16'hA55A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    ph_readout_if.master bus,
    output logic         busy,
    output logic [15:0]  frame_cnt,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  err_cnt
);

    localparam int CW = $clog2(NPIX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [CW-1:0] NPIX_C     = CW'(NPIX);
    localparam logic [CW-1:0] LAST_C     = CW'(NPIX - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DRAIN, S_FLUSH} state_e;

    state_e          state_q, state_d;
    logic            cv_d1_q;
    logic            tmr_armed_q, tmr_armed_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            ovr_q, ovr_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [CW-1:0]   issued_q, issued_d;
    logic [CW-1:0]   words_q, words_d;
    logic            inflight_q;
    logic [1:0]      skid_cnt_q, skid_cnt_d;
    logic            skid_head_q, skid_head_d;
    logic [31:0]     skid_mem [2];
    logic [15:0]     frame_q, frame_d, drop_q, drop_d, err_q, err_d;

    logic            fs, rd_en, valid, last, flush, data_acc, push, pop, skid_wr_idx;
    logic [31:0]     data;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fs = cv_d1_q & ~bus.ph_cache_valid;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tmr_armed_d = tmr_armed_q;
        tmr_d       = tmr_q;
        ovr_d       = ovr_q;
        flush_d     = flush_q;
        issued_d    = issued_q;
        words_d     = words_q;
        frame_d     = frame_q;
        drop_d      = drop_q;
        err_d       = err_q;
        rd_en       = 1'b0;
        flush       = 1'b0;
        valid       = 1'b0;
        last        = 1'b0;
        data        = '0;

        case (state_q)
            S_IDLE: begin
                if (tmr_armed_q) tmr_d = tmr_q + 1'b1;
                if (fs) begin
                    tmr_armed_d = 1'b1;
                    tmr_d       = '0;
                end
                // A complete frame beats a coincident timeout; no error is charged then.
                if (bus.ph_ready) begin
                    tmr_armed_d = 1'b0;
                    flush_d     = '0;
                    issued_d    = '0;
                    words_d     = '0;
                    if (enable) begin
                        state_d = S_HDR;
                    end else begin
                        state_d = S_FLUSH;
                        drop_d  = sat_inc(drop_q);
                    end
                end else if (tmr_armed_q && (tmr_q == TMO_LAST) && !fs) begin
                    tmr_armed_d = 1'b0;
                    flush_d     = '0;
                    state_d     = S_FLUSH;
                    err_d       = sat_inc(err_q);
                end
            end

            S_HDR: begin
                valid = 1'b1;
                data  = {HDR_TAG, frame_q};
                if (fs) begin
                    ovr_d = 1'b1;
                    err_d = sat_inc(err_q);
                end
                if (bus.out_ready) state_d = S_DRAIN;
            end

            S_DRAIN: begin
                // An empty skid lets the word returning from the FIFO flow straight through.
                valid = (skid_cnt_q != 2'd0) | inflight_q;
                data  = (skid_cnt_q != 2'd0) ? skid_mem[skid_head_q] : bus.ph_rdata;
                last  = valid & (words_q == LAST_C);
                rd_en = (issued_q != NPIX_C) & ((skid_cnt_q + {1'b0, inflight_q}) < 2'd2);
                if (rd_en) issued_d = issued_q + 1'b1;
                if (fs) begin
                    ovr_d = 1'b1;
                    err_d = sat_inc(err_q);
                end
                if (valid && bus.out_ready) begin
                    words_d = words_q + 1'b1;
                    if (last) begin
                        frame_d = frame_q + 16'd1;
                        flush_d = '0;
                        state_d = ovr_d ? S_FLUSH : S_IDLE;
                    end
                end
            end

            S_FLUSH: begin
                flush       = 1'b1;
                tmr_armed_d = 1'b0;
                tmr_d       = '0;
                ovr_d       = 1'b0;
                if (flush_q == FLUSH_LAST) state_d = S_IDLE;
                else                       flush_d = flush_q + 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign data_acc    = (state_q == S_DRAIN) & valid & bus.out_ready;
    assign pop         = data_acc & (skid_cnt_q != 2'd0);
    assign push        = inflight_q & ~(data_acc & (skid_cnt_q == 2'd0));
    assign skid_wr_idx = skid_head_q ^ skid_cnt_q[0];
    assign skid_cnt_d  = skid_cnt_q + {1'b0, push} - {1'b0, pop};
    assign skid_head_d = skid_head_q ^ pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cv_d1_q     <= 1'b0;
            tmr_armed_q <= 1'b0;
            tmr_q       <= '0;
            ovr_q       <= 1'b0;
            flush_q     <= '0;
            issued_q    <= '0;
            words_q     <= '0;
            inflight_q  <= 1'b0;
            skid_cnt_q  <= '0;
            skid_head_q <= 1'b0;
            frame_q     <= '0;
            drop_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cv_d1_q     <= bus.ph_cache_valid;
            tmr_armed_q <= tmr_armed_d;
            tmr_q       <= tmr_d;
            ovr_q       <= ovr_d;
            flush_q     <= flush_d;
            issued_q    <= issued_d;
            words_q     <= words_d;
            inflight_q  <= rd_en;
            skid_cnt_q  <= skid_cnt_d;
            skid_head_q <= skid_head_d;
            frame_q     <= frame_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

    // NOTE: skid storage is not reset; skid_cnt_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) skid_mem[skid_wr_idx] <= bus.ph_rdata;
    end

    assign bus.ph_rd_en      = rd_en;
    assign bus.ph_fifo_flush = flush;
    assign bus.out_valid     = valid;
    assign bus.out_data      = data;
    assign bus.out_last      = last;
    assign busy              = (state_q != S_IDLE);
    assign frame_cnt         = frame_q;
    assign drop_cnt          = drop_q;
    assign err_cnt           = err_q;

endmodule
